// File: rtl/stack_arb_pkg.sv
// Shared constants, op encodings and FSM state type for the two-port stack arbiter.
package stack_arb_pkg;

    localparam int unsigned DEF_DEPTH = 16;
    localparam int unsigned DEF_WIDTH = 8;

    localparam logic [1:0] OP_ILL  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH stack storage: synchronous write port, combinational read port.
module stack_mem
    import stack_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned WIDTH = DEF_WIDTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin two-port arbiter and sequencer for a LIFO stack.
// Optional feature: define STACK_ARB_PEEK_EN to enable op 11 as PEEK.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned WIDTH = DEF_WIDTH,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [3:0]         req_op,
    input  logic [2*WIDTH-1:0] req_data,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic [CW-1:0]      count,
    output logic               empty,
    output logic               full,
    output logic               busy
);

    state_t           state, state_nxt;
    logic [CW-1:0]    count_nxt;
    logic             last_grant, last_grant_nxt;
    logic [1:0]       op_q, op_nxt;
    logic [WIDTH-1:0] data_q, data_nxt;
    logic             id_q, id_nxt;
    logic [1:0]       rsp_valid_nxt;
    logic [WIDTH-1:0] rsp_data_nxt;
    logic             rsp_err_nxt;
    logic             gid;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    stack_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (AW'(count)),
        .wdata (data_q),
        .raddr (AW'(count - CW'(1))),
        .rdata (mem_rdata)
    );

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign busy  = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            last_grant <= 1'b1;
            op_q       <= OP_ILL;
            data_q     <= '0;
            id_q       <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            last_grant <= last_grant_nxt;
            op_q       <= op_nxt;
            data_q     <= data_nxt;
            id_q       <= id_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_data   <= rsp_data_nxt;
            rsp_err    <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        last_grant_nxt = last_grant;
        op_nxt         = op_q;
        data_nxt       = data_q;
        id_nxt         = id_q;
        rsp_valid_nxt  = rsp_valid;
        rsp_data_nxt   = rsp_data;
        rsp_err_nxt    = rsp_err;
        req_ready      = 2'b00;
        mem_we         = 1'b0;
        gid            = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (req_valid != 2'b00) begin
                    // On a tie the requester that did not win last time goes next.
                    gid            = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
                    req_ready      = gid ? 2'b10 : 2'b01;
                    op_nxt         = gid ? req_op[3:2] : req_op[1:0];
                    data_nxt       = gid ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
                    id_nxt         = gid;
                    last_grant_nxt = gid;
                    state_nxt      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_valid_nxt = id_q ? 2'b10 : 2'b01;
                rsp_data_nxt  = '0;
                rsp_err_nxt   = 1'b0;
                state_nxt     = S_RESP;
                case (op_q)
                    OP_PUSH: begin
                        if (!full) begin
                            mem_we    = 1'b1;
                            count_nxt = count + CW'(1);
                        end else begin
                            rsp_err_nxt = 1'b1;
                        end
                    end
                    OP_POP: begin
                        if (!empty) begin
                            rsp_data_nxt = mem_rdata;
                            count_nxt    = count - CW'(1);
                        end else begin
                            rsp_err_nxt = 1'b1;
                        end
                    end
`ifdef STACK_ARB_PEEK_EN
                    OP_PEEK: begin
                        if (!empty) begin
                            rsp_data_nxt = mem_rdata;
                        end else begin
                            rsp_err_nxt = 1'b1;
                        end
                    end
`endif
                    default: begin
                        rsp_err_nxt = 1'b1;
                    end
                endcase
            end
            S_RESP: begin
                if ((rsp_ready & rsp_valid) != 2'b00) begin
                    rsp_valid_nxt = 2'b00;
                    state_nxt     = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomized self-checking bench for stack_arbiter against a queue-based LIFO model.
module tb_stack_arbiter;

    localparam int unsigned W = 8;
    localparam int unsigned D = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [3:0]     req_op;
    logic [2*W-1:0] req_data;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic [4:0]     count;
    logic           empty;
    logic           full;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    int stk[$];
    int last_g;

    stack_arbiter #(.DEPTH(D), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input int g);
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] rand_op();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 4) return 2'b01;
        if (r <= 7) return 2'b10;
        if (r == 8) return 2'b11;
        return 2'b00;
    endfunction

    // Reference LIFO behaviour for one granted op.
    task automatic model_op(input logic [1:0] op, input logic [W-1:0] d,
                            output int ed, output int ee);
        ed = 0;
        ee = 0;
        case (op)
            2'b01: if (stk.size() < D) stk.push_back(int'(d)); else ee = 1;
            2'b10: if (stk.size() > 0) ed = stk.pop_back(); else ee = 1;
`ifdef STACK_ARB_PEEK_EN
            2'b11: if (stk.size() > 0) ed = stk[$]; else ee = 1;
`endif
            default: ee = 1;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        stk.delete();
        last_g = 1;
    endtask

    // Issues one request set, follows it through EXEC and RESP, checks every phase.
    task automatic run_op(input logic [1:0] mask, input logic [3:0] ops,
                          input logic [2*W-1:0] datas, input int stall);
        int g, ed, ee;
        logic [1:0] op;
        logic [W-1:0] d;
        req_valid = mask;
        req_op    = ops;
        req_data  = datas;
        if (mask == 2'b01) g = 0;
        else if (mask == 2'b10) g = 1;
        else g = 1 - last_g;
        @(negedge clk);
        check("grant", 32'(req_ready), 32'(onehot(g)));
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        last_g = g;
        op = ops[2*g +: 2];
        d  = datas[W*g +: W];
        model_op(op, d, ed, ee);
        @(negedge clk);
        check("exec_ready", 32'(req_ready), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        for (int s = 0; s < stall; s++) begin
            req_valid = 2'b11;
            rsp_ready = ~onehot(g);
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'(onehot(g)));
            check("stall_rsp_data", 32'(rsp_data), 32'(ed));
            check("stall_rsp_err", 32'(rsp_err), 32'(ee));
            check("stall_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        rsp_ready = onehot(g);
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'(onehot(g)));
        check("rsp_data", 32'(rsp_data), 32'(ed));
        check("rsp_err", 32'(rsp_err), 32'(ee));
        check("count", 32'(count), 32'(stk.size()));
        check("empty", 32'(empty), 32'(stk.size() == 0));
        check("full", 32'(full), 32'(stk.size() == D));
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        check("done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_op    = 4'h0;
        req_data  = '0;
        rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Single push then pop from requester 0.
        run_op(2'b01, 4'b0001, 16'h00A5, 0);
        run_op(2'b01, 4'b0010, 16'h0000, 0);

        // Tie from reset: requester 0 first, then 1; pops come back LIFO.
        do_reset();
        run_op(2'b11, 4'b0101, 16'h2211, 0);
        run_op(2'b11, 4'b0101, 16'h2211, 0);
        run_op(2'b01, 4'b0010, 16'h0000, 0);
        run_op(2'b10, 4'b1000, 16'h0000, 0);

        // Fill to full, overflow, then pop the top.
        do_reset();
        for (int i = 0; i < 16; i++) run_op(2'b01, 4'b0001, 16'(i), 0);
        run_op(2'b10, 4'b0100, 16'hFF00, 0);
        run_op(2'b01, 4'b0010, 16'h0000, 0);

        // Underflow and illegal op.
        do_reset();
        run_op(2'b01, 4'b0010, 16'h0000, 0);
        run_op(2'b10, 4'b0000, 16'h5500, 0);
        run_op(2'b01, 4'b0011, 16'h0000, 0);

        // Long response back-pressure.
        run_op(2'b01, 4'b0001, 16'h0077, 0);
        run_op(2'b01, 4'b0010, 16'h0000, 5);

        // Reset while an op is in EXEC.
        do_reset();
        for (int i = 0; i < 3; i++) run_op(2'b01, 4'b0001, 16'(8'h40 + i), 0);
        req_valid = 2'b01;
        req_op    = 4'b0001;
        req_data  = 16'h0099;
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        stk.delete();
        last_g = 1;
        @(posedge clk); #1;

        // Op 11: PEEK when enabled, illegal otherwise.
        run_op(2'b01, 4'b0001, 16'h003C, 0);
        run_op(2'b10, 4'b1100, 16'h0000, 0);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            logic [1:0] m;
            m = 2'($urandom_range(1, 3));
            run_op(m, {rand_op(), rand_op()}, 16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
